pixel_rgb_formatted: RTL and testbench



---
 rtl/pixel_rgb_formatted.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_pixel_rgb_formatted.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_rgb_formatted.sv
// pixel_rgb_formatted
//   Final shading stage of the ray-tracing pixel pipeline. One ray/block hit
//   per clock: the block material colour is quantised to 4 bits per channel,
//   dimmed by a per-face shade factor and tagged with the pixel coordinates.
//   With PIXEL_EDGE_OUTLINE_EN defined, the hit point is reconstructed on the
//   two face-tangent axes and pixels that land within EDGE_W of the block
//   rim are forced black. With the macro undefined, none of the geometry
//   datapath is built. Latency is a fixed 6 cycles either way.
//
// Parameters
//   HALF_SIZE  block half-extent, world units
//   EDGE_W     outline band width, world units
//
// Ports
//   clk_in, rst_in                       clock, async active-high reset
//   block_pos_{x,y,z}   in  32           block centre (float32)
//   block_mat_{x,y,z}   in  32           material R/G/B (float32, ~[0,1])
//   block_dir           in  3            hit face 0=-Z 1=+Z 2=-X 3=+X 4=-Y 5=+Y
//   ray_{x,y,z}         in  32           ray direction (float32)
//   t_in                in  32           hit distance (float32)
//   x_in / y_in         in  11 / 10      pixel coordinates
//   valid_in            in  1            input beat valid
//   x_out / y_out       out 11 / 10      delayed coordinates
//   r_out/g_out/b_out   out 4 each       shaded colour
//   rgb_valid           out 1            output beat valid
//
// Configuration macro: PIXEL_EDGE_OUTLINE_EN

module pixel_rgb_formatted #(
  parameter int HALF_SIZE = 50,
  parameter int EDGE_W    = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] block_pos_x,
  input  logic [31:0] block_pos_y,
  input  logic [31:0] block_pos_z,
  input  logic [31:0] block_mat_x,
  input  logic [31:0] block_mat_y,
  input  logic [31:0] block_mat_z,
  input  logic [2:0]  block_dir,
  input  logic [31:0] ray_x,
  input  logic [31:0] ray_y,
  input  logic [31:0] ray_z,
  input  logic [31:0] t_in,
  input  logic [10:0] x_in,
  input  logic [9:0]  y_in,
  input  logic        valid_in,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic [3:0]  r_out,
  output logic [3:0]  g_out,
  output logic [3:0]  b_out,
  output logic        rgb_valid
);

  // vld_pipe[k] qualifies the register stage k+1; vld_pipe[STAGES] is the
  // output register's valid.
  localparam int STAGES = 5;

  typedef enum logic [1:0] {FACE_Z, FACE_X, FACE_Y} face_e;

  function automatic face_e face_of(input logic [2:0] d);
    case (d)
      3'd2, 3'd3: return FACE_X;
      3'd4, 3'd5: return FACE_Y;
      default:    return FACE_Z;  // 0, 1 and the unused codes 6, 7
    endcase
  endfunction

  // Float32 -> 4-bit channel, round half up.
  // v = m * 2^(e-150), so round(v*15) = (15m + 2^(sh-1)) >> sh, sh = 150-e.
  // For v < 1, sh >= 24; beyond sh = 29 the result is 0, so clamp there.
  function automatic logic [3:0] u4(input logic [31:0] f);
    logic [29:0] p;
    logic [4:0]  sh;
    if (f[31] || f[30:23] == 8'd0) return 4'd0;
    if (f[30:23] >= 8'd127)        return 4'd15;
    sh = (f[30:23] < 8'd121) ? 5'd29 : 5'(8'd150 - f[30:23]);
    p  = 30'({1'b1, f[22:0]}) * 30'd15 + (30'd1 << (sh - 5'd1));
    return 4'(p >> sh);
  endfunction

  // Float32 -> int, truncate toward zero, saturate to +/-32767.
  // Exponent 142 means |v| >= 32768; that also covers Inf/NaN.
  function automatic logic signed [16:0] f2i(input logic [31:0] f);
    logic [15:0] mag;
    if (f[30:23] < 8'd127)       mag = 16'd0;
    else if (f[30:23] >= 8'd142) mag = 16'd32767;
    else                         mag = 16'({1'b1, f[22:0]} >> (8'd150 - f[30:23]));
    return f[31] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction

  logic [STAGES:0] vld_pipe;
  assign rgb_valid = vld_pipe[STAGES];

  // ---------------------------------------------------------------- stage 1
  logic [2:0][31:0] s1_mat;
  logic [2:0]       s1_dir;
  logic [10:0]      s1_x;
  logic [9:0]       s1_y;

  always_ff @(posedge clk_in) begin
    s1_mat <= {block_mat_z, block_mat_y, block_mat_x};
    s1_dir <= block_dir;
    s1_x   <= x_in;
    s1_y   <= y_in;
  end

  face_e s1_face;
  assign s1_face = face_of(s1_dir);

  // ------------------------------------------------------- stages 2..5 side
  // Colour, face and coordinates ride alongside the geometry datapath.
  logic [2:0][3:0] s2_rgb, s3_rgb, s4_rgb, s5_rgb;
  face_e           s2_face, s3_face, s4_face;
  logic [10:0]     s2_x, s3_x, s4_x, s5_x;
  logic [9:0]      s2_y, s3_y, s4_y, s5_y;

  logic [2:0][3:0] u4_n;
  logic [2:0][3:0] shade_n;
  logic [7:0]      shade_k;

  always_comb begin
    u4_n = '0;
    for (int c = 0; c < 3; c++) u4_n[c] = u4(s1_mat[c]);
  end

  // Face shade in 1/16 units, rounded: (c*S + 8) >> 4.
  always_comb begin
    case (s4_face)
      FACE_X:  shade_k = 8'd12;
      FACE_Y:  shade_k = 8'd8;
      default: shade_k = 8'd16;
    endcase
    shade_n = '0;
    for (int c = 0; c < 3; c++)
      shade_n[c] = 4'((8'(s4_rgb[c]) * shade_k + 8'd8) >> 4);
  end

  always_ff @(posedge clk_in) begin
    s2_rgb  <= u4_n;
    s2_face <= s1_face;
    s2_x    <= s1_x;
    s2_y    <= s1_y;
    s3_rgb  <= s2_rgb;
    s3_face <= s2_face;
    s3_x    <= s2_x;
    s3_y    <= s2_y;
    s4_rgb  <= s3_rgb;
    s4_face <= s3_face;
    s4_x    <= s3_x;
    s4_y    <= s3_y;
    s5_rgb  <= shade_n;
    s5_x    <= s4_x;
    s5_y    <= s4_y;
  end

`ifdef PIXEL_EDGE_OUTLINE_EN
  localparam logic [17:0] EDGE_LIM = 18'(HALF_SIZE - EDGE_W);

  logic [2:0][31:0] s1_pos, s1_ray;
  logic [31:0]      s1_t;

  always_ff @(posedge clk_in) begin
    s1_pos <= {block_pos_z, block_pos_y, block_pos_x};
    s1_ray <= {ray_z, ray_y, ray_x};
    s1_t   <= t_in;
  end

  // Tangent axes of the hit face: Z->(x,y), X->(y,z), Y->(x,z).
  logic [1:0][31:0] tan_ray, tan_pos;
  always_comb begin
    tan_ray = {s1_ray[1], s1_ray[0]};
    tan_pos = {s1_pos[1], s1_pos[0]};
    case (s1_face)
      FACE_X: begin
        tan_ray = {s1_ray[2], s1_ray[1]};
        tan_pos = {s1_pos[2], s1_pos[1]};
      end
      FACE_Y: begin
        tan_ray = {s1_ray[2], s1_ray[0]};
        tan_pos = {s1_pos[2], s1_pos[0]};
      end
      default: ;
    endcase
  end

  // Stage 2: mantissa multiply. Only the top 25 product bits survive; the
  // float result truncates, so the rest is dropped here.
  logic [1:0][47:0] mul_full;
  logic             unused_mul_lsb;
  always_comb begin
    mul_full = '0;
    for (int i = 0; i < 2; i++)
      mul_full[i] = 48'({1'b1, s1_t[22:0]}) * 48'({1'b1, tan_ray[i][22:0]});
  end
  assign unused_mul_lsb = ^{mul_full[1][22:0], mul_full[0][22:0]};

  logic [1:0][24:0] s2_prod;
  logic [1:0][9:0]  s2_exp;     // biased, two's complement, may be <=0 or >254
  logic [1:0]       s2_sgn, s2_inf, s2_zero;
  logic [1:0][16:0] s2_pos_i;

  always_ff @(posedge clk_in) begin
    for (int i = 0; i < 2; i++) begin
      s2_prod[i]  <= mul_full[i][47:23];
      s2_exp[i]   <= 10'({2'b0, s1_t[30:23]}) + 10'({2'b0, tan_ray[i][30:23]}) - 10'd127;
      s2_sgn[i]   <= s1_t[31] ^ tan_ray[i][31];
      // Inf/NaN wins over zero so that Inf*0 still saturates.
      s2_inf[i]   <= (&s1_t[30:23]) | (&tan_ray[i][30:23]);
      s2_zero[i]  <= ~(|s1_t[30:23]) | ~(|tan_ray[i][30:23]);
      s2_pos_i[i] <= f2i(tan_pos[i]);
    end
  end

  // Stage 3: normalise back to a float32 so stage 4 can reuse f2i.
  logic [1:0][9:0]  exp_n;
  logic [1:0][31:0] h_n;
  always_comb begin
    exp_n = '0;
    h_n   = '0;
    for (int i = 0; i < 2; i++) begin
      exp_n[i] = 10'($signed(s2_exp[i]) + $signed({9'd0, s2_prod[i][24]}));
      if (s2_inf[i])
        h_n[i] = {s2_sgn[i], 8'hff, 23'd0};
      else if (s2_zero[i] || $signed(exp_n[i]) <= 10'sd0)
        h_n[i] = 32'd0;
      else if ($signed(exp_n[i]) >= 10'sd255)
        h_n[i] = {s2_sgn[i], 8'hff, 23'd0};
      else
        h_n[i] = {s2_sgn[i], exp_n[i][7:0],
                  s2_prod[i][24] ? s2_prod[i][23:1] : s2_prod[i][22:0]};
    end
  end

  logic [1:0][31:0] s3_h;
  logic [1:0][16:0] s3_pos_i;
  logic [1:0][16:0] s4_h_i, s4_pos_i;
  logic             s5_blk;

  always_ff @(posedge clk_in) begin
    s3_h     <= h_n;
    s3_pos_i <= s2_pos_i;
    for (int i = 0; i < 2; i++) s4_h_i[i] <= f2i(s3_h[i]);
    s4_pos_i <= s3_pos_i;
  end

  // Stage 5: local offset from block centre; 18 bits holds +/-65534.
  logic [1:0][17:0] loc_d, mag_d;
  logic             edge_n;
  always_comb begin
    loc_d  = '0;
    mag_d  = '0;
    edge_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      loc_d[i] = 18'($signed(s4_h_i[i])) - 18'($signed(s4_pos_i[i]));
      mag_d[i] = loc_d[i][17] ? -loc_d[i] : loc_d[i];
      if (mag_d[i] >= EDGE_LIM) edge_n = 1'b1;
    end
  end

  always_ff @(posedge clk_in) s5_blk <= edge_n;
`else
  logic s5_blk;
  logic unused_geom;
  assign s5_blk      = 1'b0;
  assign unused_geom = ^{block_pos_x, block_pos_y, block_pos_z, ray_x, ray_y,
                         ray_z, t_in, 32'(HALF_SIZE), 32'(EDGE_W)};
`endif

  // ---------------------------------------------------- stage 6 / outputs
  // Outputs only update on a valid beat and otherwise hold.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      vld_pipe <= '0;
      x_out    <= '0;
      y_out    <= '0;
      r_out    <= '0;
      g_out    <= '0;
      b_out    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], valid_in};
      if (vld_pipe[STAGES-1]) begin
        x_out <= s5_x;
        y_out <= s5_y;
        r_out <= s5_blk ? 4'd0 : s5_rgb[0];
        g_out <= s5_blk ? 4'd0 : s5_rgb[1];
        b_out <= s5_blk ? 4'd0 : s5_rgb[2];
      end
    end
  end

endmodule

// File: tb/tb_pixel_rgb_formatted.sv
// Bench for pixel_rgb_formatted: directed plan items plus randomized beats
// checked against a real-arithmetic reference model and a per-cycle
// expectation table. Honours PIXEL_EDGE_OUTLINE_EN like the design.
module tb_pixel_rgb_formatted;
  localparam int HALF_SIZE = 50;
  localparam int EDGE_W    = 4;
  localparam int DEPTH     = 8192;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [31:0] block_pos_x = '0, block_pos_y = '0, block_pos_z = '0;
  logic [31:0] block_mat_x = '0, block_mat_y = '0, block_mat_z = '0;
  logic [2:0]  block_dir = '0;
  logic [31:0] ray_x = '0, ray_y = '0, ray_z = '0, t_in = '0;
  logic [10:0] x_in = '0;
  logic [9:0]  y_in = '0;
  logic        valid_in = 1'b0;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic [3:0]  r_out, g_out, b_out;
  logic        rgb_valid;

  pixel_rgb_formatted #(.HALF_SIZE(HALF_SIZE), .EDGE_W(EDGE_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .block_pos_x(block_pos_x), .block_pos_y(block_pos_y), .block_pos_z(block_pos_z),
    .block_mat_x(block_mat_x), .block_mat_y(block_mat_y), .block_mat_z(block_mat_z),
    .block_dir(block_dir), .ray_x(ray_x), .ray_y(ray_y), .ray_z(ray_z), .t_in(t_in),
    .x_in(x_in), .y_in(y_in), .valid_in(valid_in),
    .x_out(x_out), .y_out(y_out), .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .rgb_valid(rgb_valid)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [2:0][31:0] pos, mat, ray;
    logic [31:0]      t;
    logic [2:0]       dir;
    logic [10:0]      x;
    logic [9:0]       y;
    bit               v;
  } beat_t;

  int          n_vec = 0, n_err = 0;
  int          cyc = 0;
  bit          exp_v [DEPTH];
  logic [32:0] exp_d [DEPTH];

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h, want %0h", tag, cyc, act, want);
    end
  endtask

  // ---------------------------------------------------------------- model
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0)  return 0.0;
    if (f[30:23] == 8'hff) return f[31] ? -1.0e300 : 1.0e300;
    d = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int          e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 896;
    if (e <= 0)   return {d[63], 31'd0};
    if (e >= 255) return {d[63], 8'hff, 23'd0};
    return {d[63], 8'(e), d[51:29]};
  endfunction

  function automatic int q4(input logic [31:0] f);
    real v;
    if (f[31] || f[30:23] == 8'd0) return 0;
    if (f[30:23] == 8'hff)         return 15;
    v = f2r(f);
    if (v >= 1.0) return 15;
    return $rtoi(v * 15.0 + 0.5);
  endfunction

  function automatic int sat_trunc(input real r);
    if (r >= 32767.0)  return 32767;
    if (r <= -32767.0) return -32767;
    return $rtoi(r);
  endfunction

  function automatic bit near_rim(input logic [31:0] t, input logic [31:0] ray, input logic [31:0] pos);
    int l;
    l = sat_trunc(f2r(t) * f2r(ray)) - sat_trunc(f2r(pos));
    return ((l < 0) ? -l : l) >= HALF_SIZE - EDGE_W;
  endfunction

  function automatic logic [11:0] model(input beat_t b);
    int  s, a0, a1;
    bit  blk;
    int  c [3];
    for (int i = 0; i < 3; i++) c[i] = q4(b.mat[i]);
    case (b.dir)
      3'd2, 3'd3: begin s = 12; a0 = 1; a1 = 2; end
      3'd4, 3'd5: begin s = 8;  a0 = 0; a1 = 2; end
      default:    begin s = 16; a0 = 0; a1 = 1; end
    endcase
    blk = 1'b0;
`ifdef PIXEL_EDGE_OUTLINE_EN
    blk = near_rim(b.t, b.ray[a0], b.pos[a0]) || near_rim(b.t, b.ray[a1], b.pos[a1]);
`endif
    if (blk) return 12'd0;
    return {4'((c[0] * s + 8) / 16), 4'((c[1] * s + 8) / 16), 4'((c[2] * s + 8) / 16)};
  endfunction

  // -------------------------------------------------------------- stimulus
  function automatic beat_t centre_beat();
    beat_t b;
    b.pos = {r2f(1000.0), 32'd0, 32'd0};
    b.ray = {r2f(1.0), 32'd0, 32'd0};
    b.t   = r2f(1000.0);
    b.mat = {r2f(1.0), r2f(1.0), r2f(1.0)};
    b.dir = 3'd1;
    b.x   = 11'd100;
    b.y   = 10'd50;
    b.v   = 1'b1;
    return b;
  endfunction

  function automatic beat_t rnd_beat();
    beat_t b;
    real   h;
    b.v   = ($urandom_range(0, 3) != 0);
    b.dir = 3'($urandom_range(0, 7));
    b.x   = 11'($urandom);
    b.y   = 10'($urandom);
    for (int c = 0; c < 3; c++)
      b.mat[c] = ($urandom_range(0, 3) == 0) ? 32'($urandom)
               : r2f((real'($urandom_range(0, 1400)) - 200.0) / 1000.0);
    b.t = ($urandom_range(0, 9) == 0) ? r2f(real'($urandom_range(0, 100000)) * 10.0)
                                      : r2f(real'($urandom_range(0, 30000)) / 10.0);
    for (int a = 0; a < 3; a++)
      b.ray[a] = r2f((real'($urandom_range(0, 2000)) - 1000.0) / 1000.0);
    for (int a = 0; a < 3; a++) begin
      h = f2r(b.t) * f2r(b.ray[a]);
      b.pos[a] = ($urandom_range(0, 9) == 0) ? r2f(real'($urandom_range(0, 100000)) - 50000.0)
               : r2f(h - (real'($urandom_range(0, 1200)) - 600.0) / 10.0);
    end
    return b;
  endfunction

  // Drive one beat (just after a rising edge); its result is due at the
  // negedge following rising edge cyc+6.
  task automatic send(input beat_t b, input bit use_k, input logic [11:0] k);
    {block_pos_z, block_pos_y, block_pos_x} = b.pos;
    {block_mat_z, block_mat_y, block_mat_x} = b.mat;
    {ray_z, ray_y, ray_x} = b.ray;
    t_in      = b.t;
    block_dir = b.dir;
    x_in      = b.x;
    y_in      = b.y;
    valid_in  = b.v;
    exp_v[cyc + 6] = b.v && !rst_in;
    exp_d[cyc + 6] = {b.x, b.y, use_k ? k : model(b)};
    @(posedge clk_in); #1;
  endtask

  task automatic idle(input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b = rnd_beat();
      b.v = 1'b0;
      send(b, 1'b0, 12'd0);
    end
  endtask

  task automatic reset_on();
    rst_in = 1'b1;
    for (int i = 1; i <= 6; i++) exp_v[cyc + i] = 1'b0;
  endtask

  // -------------------------------------------------------------- monitor
  always @(negedge clk_in) begin
    if (rst_in) begin
      chk("rst_valid", 64'(rgb_valid), 64'd0);
      chk("rst_data", 64'({x_out, y_out, r_out, g_out, b_out}), 64'd0);
    end else begin
      chk("valid", 64'(rgb_valid), 64'(exp_v[cyc]));
      if (exp_v[cyc])
        chk("pixel", 64'({x_out, y_out, r_out, g_out, b_out}), 64'(exp_d[cyc]));
    end
  end

  // ----------------------------------------------------------------- main
  initial begin
    beat_t b;
    logic [11:0] outline_rgb;
`ifdef PIXEL_EDGE_OUTLINE_EN
    outline_rgb = 12'h000;
`else
    outline_rgb = 12'hfff;
`endif
    @(posedge clk_in); #1;

    // Reset held with valid beats presented: nothing may come out.
    reset_on();
    for (int i = 0; i < 10; i++) begin
      b = rnd_beat();
      b.v = 1'b1;
      send(b, 1'b0, 12'd0);
    end
    rst_in = 1'b0;
    idle(8);

    // Centre hit on +Z, red material.
    b = centre_beat();
    b.mat = {32'd0, 32'd0, r2f(1.0)};
    send(b, 1'b1, 12'hf00);

    // Face factors with white material.
    b = centre_beat(); b.dir = 3'd2; send(b, 1'b1, 12'hbbb);
    b = centre_beat(); b.dir = 3'd4; send(b, 1'b1, 12'h888);
    b = centre_beat(); b.dir = 3'd7; send(b, 1'b1, 12'hfff);

    // Quantisation on -Z.
    b = centre_beat(); b.dir = 3'd0;
    b.mat = {r2f(2.0), r2f(-0.3), r2f(0.5)};
    send(b, 1'b1, 12'h80f);
    b.mat = {32'd0, 32'd0, r2f(0.0333)}; send(b, 1'b1, 12'h000);
    b.mat = {32'd0, 32'd0, r2f(0.0334)}; send(b, 1'b1, 12'h100);

    // Outline band: local x = 48 (in band), then 45 (inside).
    b = centre_beat(); b.dir = 3'd0;
    b.pos = {r2f(1000.0), 32'd0, r2f(-48.0)};
    send(b, 1'b1, outline_rgb);
    b.pos = {r2f(1000.0), 32'd0, r2f(-45.0)};
    send(b, 1'b1, 12'hfff);
    idle(8);

    // Two back-to-back beats then a gap.
    b = centre_beat(); b.x = 11'd100; send(b, 1'b0, 12'd0);
    b = centre_beat(); b.x = 11'd101; send(b, 1'b0, 12'd0);
    idle(8);

    // Reset pulse while two beats are in flight drops both.
    b = centre_beat(); b.x = 11'd200; send(b, 1'b0, 12'd0);
    b = centre_beat(); b.x = 11'd201; send(b, 1'b0, 12'd0);
    idle(2);
    reset_on();
    idle(1);
    rst_in = 1'b0;
    b = centre_beat(); b.x = 11'd300; send(b, 1'b0, 12'd0);
    idle(8);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      b = rnd_beat();
      send(b, 1'b0, 12'd0);
    end
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
